video_line_fetch: RTL and testbench

- Streams a linear framebuffer out of SDRAM through read-only port 1 of the bus arbiter.
- Buffers the fetched words in a small FIFO and serialises each 32-bit word into DATA_BITS-wide pixels.
- Sits between the arbiter (upstream) and the NTSC pixel generator (downstream).
- Single clock domain; any crossing into the NTSC clock is handled outside this block.

---
 rtl/video_line_fetch.sv | 197 +++++++++++++++++++
 tb/tb_video_line_fetch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_line_fetch.sv
// video_line_fetch
//   Streams a linear framebuffer out of SDRAM through read-only arbiter
//   port 1. Fetched words go into a small word FIFO. The head word is
//   serialised LSB-first into DATA_BITS-wide pixels for the pixel generator.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   frame_start     one-cycle pulse at the frame boundary; restarts the stream
//   addr1           arbiter port-1 word address (stable while req_read1=1)
//   req_read1       arbiter port-1 read request (one read outstanding at most)
//   data1           arbiter port-1 read data
//   data_valid1     arbiter port-1 read data strobe
//   pix_ready       consumer takes the current pixel this cycle
//   pix_valid       pix_data holds a valid pixel (FIFO non-empty)
//   pix_data        current pixel
//   underflow       pix_ready while no pixel is available
//   fifo_level      words currently held in the FIFO
module video_line_fetch #(
    parameter int          DATA_BITS   = 4,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [23:0] FRAME_BASE  = 24'h000000,
    parameter logic [23:0] FRAME_WORDS = 24'd4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    output logic [23:0]                   addr1,
    output logic                          req_read1,
    input  logic [31:0]                   data1,
    input  logic                          data_valid1,
    input  logic                          pix_ready,
    output logic                          pix_valid,
    output logic [DATA_BITS-1:0]          pix_data,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PIX_PER_WORD = 32 / DATA_BITS;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int LVL_W        = PTR_W + 1;
    localparam int IDX_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PIX_PER_WORD - 1);
    localparam logic [23:0]      LAST_WORD  = FRAME_WORDS - 24'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [23:0]        addr_reg;
    logic [23:0]        word_cnt_reg;
    logic               drop_reg;

    logic [31:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]   count_reg;
    logic [IDX_W-1:0]   idx_reg;

    logic               rd_fire;
    logic               push;
    logic               pop_pix;
    logic               pop_word;
    logic [31:0]        head_word;
    logic [DATA_BITS-1:0] lane [PIX_PER_WORD];

    // A read completes only while requesting; strobes seen elsewhere are noise.
    assign rd_fire  = data_valid1 && (state_reg == ST_REQ);
    // Words belonging to an aborted frame, or landing on a restart, are discarded.
    assign push     = rd_fire && !drop_reg && !frame_start;
    assign pop_pix  = pix_valid && pix_ready;
    assign pop_word = pop_pix && (idx_reg == LAST_IDX) && !frame_start;

    //------------------------------------------------------------------
    // Fetch FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    //------------------------------------------------------------------
    // Fetch FSM: next state
    //------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (!frame_start && (count_reg < FULL_LEVEL)) state_next = ST_REQ;
            // An outstanding read must complete even across a frame restart.
            ST_REQ:  if (rd_fire) state_next = ST_GAP;
            ST_GAP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (frame_start && (state_reg != ST_REQ)) begin
            state_next = ST_IDLE;
        end
    end

    //------------------------------------------------------------------
    // Fetch FSM: outputs
    //------------------------------------------------------------------
    always_comb begin
        req_read1 = (state_reg == ST_REQ);
    end

    assign addr1 = addr_reg;

    //------------------------------------------------------------------
    // Address, frame word counter and drop flag
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg     <= FRAME_BASE;
            word_cnt_reg <= '0;
            drop_reg     <= 1'b0;
        end else if (rd_fire) begin
            drop_reg <= 1'b0;
            if (drop_reg || frame_start || (word_cnt_reg == LAST_WORD)) begin
                addr_reg     <= FRAME_BASE;
                word_cnt_reg <= '0;
            end else begin
                addr_reg     <= addr_reg + 24'd1;
                word_cnt_reg <= word_cnt_reg + 24'd1;
            end
        end else if (frame_start) begin
            if (state_reg == ST_REQ) begin
                // Address must stay stable until the pending read returns;
                // the restart to FRAME_BASE is applied when it does.
                drop_reg <= 1'b1;
            end else begin
                addr_reg     <= FRAME_BASE;
                word_cnt_reg <= '0;
            end
        end
    end

    //------------------------------------------------------------------
    // Word FIFO storage (no reset needed; validity tracked by count_reg)
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data1;
        end
    end

    //------------------------------------------------------------------
    // FIFO pointers, level and pixel index
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            idx_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_word) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop_word})
                2'b10:   count_reg <= count_reg + LVL_W'(1);
                2'b01:   count_reg <= count_reg - LVL_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (pop_pix) begin
                idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
            end
        end
    end

    //------------------------------------------------------------------
    // Pixel serialiser: the head word is read asynchronously so the pixel
    // is available in the same cycle the index or pointer moves.
    //------------------------------------------------------------------
    assign head_word = mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
            assign lane[gi] = head_word[gi*DATA_BITS +: DATA_BITS];
        end
    endgenerate

    assign pix_valid  = (count_reg != '0);
    // Masked while empty so stale or uninitialised storage never shows.
    assign pix_data   = pix_valid ? lane[idx_reg] : '0;
    assign underflow  = pix_ready && !pix_valid;
    assign fifo_level = count_reg;

endmodule

// File: tb/tb_video_line_fetch.sv
module tb_video_line_fetch;

    localparam int          DB    = 4;
    localparam int          DEPTH = 16;
    localparam int          PPW   = 32 / DB;
    localparam int          FW_I  = 6;
    localparam logic [23:0] BASE  = 24'h000A00;
    localparam logic [23:0] FW    = 24'd6;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [23:0] addr1;
    logic        req_read1;
    logic [31:0] data1;
    logic        data_valid1;
    logic        pix_ready;
    logic        pix_valid;
    logic [DB-1:0] pix_data;
    logic        underflow;
    logic [$clog2(DEPTH):0] fifo_level;

    video_line_fetch #(
        .DATA_BITS  (DB),
        .FIFO_DEPTH (DEPTH),
        .FRAME_BASE (BASE),
        .FRAME_WORDS(FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .addr1      (addr1),
        .req_read1  (req_read1),
        .data1      (data1),
        .data_valid1(data_valid1),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .underflow  (underflow),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected pixel stream and expected request addresses.
    int          pix_q[$];
    int          exp_n;
    // Arbiter model
    bit          busy;
    bit          drop_cur;
    bit          deliver_now;
    bit          just_delivered;
    bit          new_req;
    int          wait_cnt;
    int          lat;
    int          req_count;
    logic [23:0] busy_addr;
    bit          override_en;
    logic [31:0] override_word;
    logic [31:0] seed;

    int checks;
    int errors;

    function automatic logic [31:0] word_for(input logic [23:0] a);
        if (a == BASE) return 32'h76543210;
        return ({8'h00, a} * 32'h9E3779B1) ^ seed;
    endfunction

    function automatic int model_level();
        return (pix_q.size() + PPW - 1) / PPW;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check settled outputs, drive inputs, clock, update model.
    task automatic tick(input bit ready, input bit fs);
        logic [31:0] w;
        new_req = 0;
        chk("pix_valid", {31'b0, pix_valid}, {31'b0, pix_q.size() > 0});
        if (pix_q.size() > 0) chk("pix_data", {28'b0, pix_data}, pix_q[0]);
        chk("fifo_level", {27'b0, fifo_level}, model_level());
        if (just_delivered) begin
            chk("req_drop_after_dv", {31'b0, req_read1}, 32'd0);
        end else if (req_read1 && !busy) begin
            new_req   = 1;
            busy      = 1;
            wait_cnt  = 0;
            drop_cur  = 0;
            busy_addr = addr1;
            chk("req_addr", {8'b0, addr1}, {8'b0, BASE + 24'(exp_n)});
            exp_n = (exp_n + 1) % FW_I;
            req_count++;
        end else if (busy) begin
            chk("req_held", {31'b0, req_read1}, 32'd1);
            chk("addr_stable", {8'b0, addr1}, {8'b0, busy_addr});
        end

        pix_ready   = ready;
        frame_start = fs;
        data_valid1 = 1'b0;
        deliver_now = 0;
        if (busy) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
                deliver_now = 1;
                data_valid1 = 1'b1;
                data1       = override_en ? override_word : word_for(busy_addr);
                override_en = 0;
            end
        end else if ($urandom_range(7) == 0) begin
            // Stray strobe outside a request must be ignored.
            data_valid1 = 1'b1;
            data1       = $urandom;
        end
        #1;
        chk("underflow", {31'b0, underflow}, {31'b0, ready && (pix_q.size() == 0)});

        @(posedge clk);
        #1;
        just_delivered = deliver_now;
        if (fs) begin
            pix_q.delete();
            exp_n = 0;
            if (busy && !deliver_now) drop_cur = 1;
        end else if (ready && pix_q.size() > 0) begin
            void'(pix_q.pop_front());
        end
        if (deliver_now) begin
            busy = 0;
            if (!fs && !drop_cur) begin
                w = data1;
                for (int k = 0; k < PPW; k++) pix_q.push_back(int'((w >> (k * DB)) & 32'hF));
            end
            drop_cur = 0;
        end
        data_valid1 = 1'b0;
    endtask

    initial begin
        int          rc;
        int          guard;
        bit          found;
        logic [31:0] w;

        checks = 0; errors = 0;
        exp_n = 0; busy = 0; drop_cur = 0; deliver_now = 0; just_delivered = 0;
        new_req = 0; wait_cnt = 0; req_count = 0; override_en = 0;
        override_word = 32'h0; busy_addr = '0;
        seed = $urandom;
        lat  = 3;

        rst = 1'b1; frame_start = 1'b0; pix_ready = 1'b0;
        data1 = 32'h0; data_valid1 = 1'b0;

        // Reset, with a frame_start pulse inside it (reset wins).
        repeat (2) @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_addr1", {8'b0, addr1}, {8'b0, BASE});
        chk("rst_req", {31'b0, req_read1}, 32'd0);
        chk("rst_pix_valid", {31'b0, pix_valid}, 32'd0);
        chk("rst_pix_data", {28'b0, pix_data}, 32'd0);
        chk("rst_underflow", {31'b0, underflow}, 32'd0);
        chk("rst_level", {27'b0, fifo_level}, 32'd0);
        rst = 1'b0;

        // Consumer ready from the start: underflow until the first word lands,
        // then 0..7 from the BASE word, then the BASE+1 word.
        lat = 3;
        repeat (40) tick(1, 0);

        // Fill with the consumer stalled: level saturates at DEPTH.
        repeat (150) begin
            lat = 1 + $urandom_range(3);
            tick(0, 0);
        end
        chk("full_level", {27'b0, fifo_level}, DEPTH);
        chk("full_no_req", {31'b0, req_read1}, 32'd0);
        rc = req_count;
        repeat (20) tick(0, 0);
        chk("full_req_count", req_count, rc);
        // Free exactly one word, then expect exactly one refill request.
        guard = 0;
        while (model_level() == DEPTH && guard < 2 * PPW) begin
            tick(1, 0);
            guard++;
        end
        rc = req_count;
        repeat (20) tick(0, 0);
        chk("one_refill", req_count, rc + 1);
        chk("refill_level", {27'b0, fifo_level}, DEPTH);

        // Mostly continuous consumption: addresses wrap BASE..BASE+5.
        repeat (400) begin
            lat = 1 + $urandom_range(3);
            tick($urandom_range(3) != 0, 0);
        end

        // frame_start while a request to BASE+5 is outstanding.
        lat = 3;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick(1, 0);
            if (new_req && busy_addr == BASE + 24'd5) found = 1;
        end
        chk("found_addr5", {31'b0, found}, 32'd1);
        override_en   = 1;
        override_word = 32'hDEADBEEF;
        tick(1, 1);
        chk("fs_level", {27'b0, fifo_level}, 32'd0);
        chk("fs_pix_valid", {31'b0, pix_valid}, 32'd0);
        repeat (30) tick(1, 0);

        // Last pixel of the only word pops in the same cycle a new word lands.
        lat = 9;
        tick(0, 1);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick(0, 0);
            if (new_req && pix_q.size() == PPW) found = 1;
        end
        chk("pp_setup", {31'b0, found}, 32'd1);
        repeat (PPW) tick(1, 0);
        w = word_for(BASE + 24'd1);
        chk("pp_level", {27'b0, fifo_level}, 32'd1);
        chk("pp_nibble0", {28'b0, pix_data}, {28'b0, w[3:0]});
        tick(0, 0);

        // Random mix including random frame restarts.
        repeat (500) begin
            lat = 1 + $urandom_range(4);
            tick($urandom_range(3) != 0, $urandom_range(59) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
